// File: rtl/link_pkg.sv
// Constants shared by the framer and the far-end header detector, plus the framer state encoding.
package link_pkg;

  localparam int unsigned WIDTH       = 16;
  localparam logic [15:0] HDR_WORD    = 16'hFFFF;
  localparam int unsigned HDR_LEN     = 3;
  localparam int unsigned PAYLOAD_LEN = 10;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam logic [15:0] IDLE_WORD   = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPay
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is combinationally visible on rd_data.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  // Full is checked before any same-cycle pop, so a push into a full FIFO is always refused.
  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

  // Storage array; no reset needed, contents are qualified by the level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (!do_push && do_pop) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

endmodule

// File: rtl/header_framer.sv
// Transmit framer: buffers payload, then emits HDR_LEN header words followed by PAYLOAD_LEN
// payload words once a whole frame is buffered. Drives IDLE_WORD between frames.
module header_framer #(
  parameter int unsigned      WIDTH       = link_pkg::WIDTH,
  parameter logic [WIDTH-1:0] HDR_WORD    = link_pkg::HDR_WORD,
  parameter int unsigned      HDR_LEN     = link_pkg::HDR_LEN,
  parameter int unsigned      PAYLOAD_LEN = link_pkg::PAYLOAD_LEN,
  parameter int unsigned      FIFO_DEPTH  = link_pkg::FIFO_DEPTH,
  parameter logic [WIDTH-1:0] IDLE_WORD   = link_pkg::IDLE_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] outp,
  output logic             frame_start,
  output logic             busy
);

  import link_pkg::*;

  localparam int unsigned LvlW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned HdrCntW = $clog2(HDR_LEN + 1);
  localparam int unsigned PayCntW = $clog2(PAYLOAD_LEN + 1);

  localparam logic [LvlW-1:0]    PayLenLvl = LvlW'(PAYLOAD_LEN);
  localparam logic [HdrCntW-1:0] HdrLast   = HdrCntW'(HDR_LEN);
  localparam logic [PayCntW-1:0] PayLast   = PayCntW'(PAYLOAD_LEN);

  state_e               state_q, state_d;
  logic [HdrCntW-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [PayCntW-1:0]   pay_cnt_q, pay_cnt_d;
  logic [WIDTH-1:0]     outp_q, outp_d;
  logic                 frame_start_q, frame_start_d;
  logic                 busy_q, busy_d;

  logic                 push, pop_req, pop;
  logic                 fifo_full, fifo_empty;
  logic [WIDTH-1:0]     fifo_head;
  logic [LvlW-1:0]      level;
  logic [LvlW-1:0]      lvl_after_push;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = pop_req && !fifo_empty;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Level after this cycle's push; used at end of payload where no pop occurs.
  always_comb begin
    lvl_after_push = level;
    if (push) begin
      lvl_after_push = level + LvlW'(1);
    end
  end

  // Next-state and registered-output logic; counters hold the number of words already driven.
  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    pay_cnt_d     = pay_cnt_q;
    outp_d        = IDLE_WORD;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    pop_req       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level >= PayLenLvl) begin
          state_d       = StHdr;
          outp_d        = HDR_WORD;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
          hdr_cnt_d     = HdrCntW'(1);
        end
      end
      StHdr: begin
        busy_d = 1'b1;
        if (hdr_cnt_q != HdrLast) begin
          outp_d    = HDR_WORD;
          hdr_cnt_d = hdr_cnt_q + HdrCntW'(1);
        end else begin
          state_d   = StPay;
          pop_req   = 1'b1;
          outp_d    = fifo_head;
          pay_cnt_d = PayCntW'(1);
        end
      end
      StPay: begin
        if (pay_cnt_q != PayLast) begin
          busy_d    = 1'b1;
          pop_req   = 1'b1;
          outp_d    = fifo_head;
          pay_cnt_d = pay_cnt_q + PayCntW'(1);
        end else if (lvl_after_push >= PayLenLvl) begin
          // Next frame already buffered: header follows the last payload word with no gap.
          state_d       = StHdr;
          outp_d        = HDR_WORD;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
          hdr_cnt_d     = HdrCntW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and link output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      hdr_cnt_q     <= '0;
      pay_cnt_q     <= '0;
      outp_q        <= IDLE_WORD;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      pay_cnt_q     <= pay_cnt_d;
      outp_q        <= outp_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign outp        = outp_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_header_framer.sv
// Scoreboard bench for header_framer: the stimulus side predicts each frame into a queue,
// the monitor compares every output cycle and feeds a loopback header detector.
module tb_header_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] outp;
  logic        frame_start;
  logic        busy;

  typedef struct {
    logic [15:0] word;
    logic        first;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pend_q[$];
  logic [15:0] det_q[$];

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int busy_runs = 0;
  int ready_low_cnt = 0;
  int det_run = 0;
  int det_win = 0;
  bit prev_busy = 1'b0;

  always #5 clk = ~clk;

  header_framer dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .outp        (outp),
    .frame_start (frame_start),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference framing: every 10 accepted words become 3 header words then the 10 words.
  task automatic model_accept(input logic [15:0] w);
    exp_t e;
    pend_q.push_back(w);
    if (pend_q.size() == 10) begin
      for (int i = 0; i < 3; i++) begin
        e.word  = 16'hFFFF;
        e.first = (i == 0);
        exp_q.push_back(e);
      end
      foreach (pend_q[i]) begin
        e.word  = pend_q[i];
        e.first = 1'b0;
        exp_q.push_back(e);
      end
      pend_q.delete();
    end
  endtask

  // Offer one word; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [15:0] w);
    bit acc = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("push_accepted", {31'd0, acc}, 32'd1);
    if (acc) model_accept(w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    pend_q.delete();
    #1;
    check("rst_outp", {16'd0, outp}, 32'h0000);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_frame_start", {31'd0, frame_start}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: scoreboard compare plus loopback header detector.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      det_run   = 0;
      det_win   = 0;
      prev_busy = 1'b0;
    end else begin
      if (in_valid && !in_ready) ready_low_cnt++;
      if (busy) begin
        busy_cnt++;
        if (!prev_busy) busy_runs++;
        if (exp_q.size() == 0) begin
          check("busy_without_frame", {31'd0, busy}, 0);
        end else begin
          e = exp_q.pop_front();
          check("outp", {16'd0, outp}, {16'd0, e.word});
          check("frame_start", {31'd0, frame_start}, {31'd0, e.first});
        end
      end else begin
        check("idle_outp", {16'd0, outp}, 32'h0000);
        check("idle_frame_start", {31'd0, frame_start}, 0);
      end
      prev_busy = busy;
      if (det_win > 0) begin
        det_q.push_back(outp);
        det_win--;
      end else if (outp == 16'hFFFF) begin
        det_run++;
        if (det_run == 3) begin
          det_win = 10;
          det_run = 0;
        end
      end else begin
        det_run = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("init_outp", {16'd0, outp}, 32'h0000);
    check("init_busy", {31'd0, busy}, 0);
    check("init_frame_start", {31'd0, frame_start}, 0);
    check("init_in_ready", {31'd0, in_ready}, 1);

    // Reset with 5 words buffered; those words must be discarded.
    for (int i = 1; i <= 5; i++) push_word(16'h0100 + 16'(i));
    idle(3);
    do_reset();
    idle(20);

    // One plain frame 0x0001..0x000A.
    for (int i = 1; i <= 10; i++) push_word(16'(i));
    drain();
    idle(5);

    // Nine words stay buffered; the tenth starts a frame one cycle after acceptance.
    for (int i = 1; i <= 9; i++) push_word((i == 5) ? 16'hFFFF : 16'h0200 + 16'(i));
    idle(30);
    push_word(16'h020A);
    check("latency_busy_t", {31'd0, busy}, 0);
    check("latency_fs_t", {31'd0, frame_start}, 0);
    @(posedge clk);
    #1;
    check("latency_fs_t1", {31'd0, frame_start}, 1);
    check("latency_outp_t1", {16'd0, outp}, 32'hFFFF);
    drain();
    idle(5);

    // Twenty words streamed: two back-to-back frames, detector recovers all payload.
    det_q.delete();
    busy_cnt  = 0;
    busy_runs = 0;
    for (int i = 1; i <= 20; i++) push_word(16'h0300 + 16'(i));
    drain();
    idle(3);
    check("b2b_busy_cycles", busy_cnt, 26);
    check("b2b_busy_runs", busy_runs, 1);
    check("det_count", det_q.size(), 20);
    foreach (det_q[i]) check("det_word", {16'd0, det_q[i]}, 32'h0300 + 32'(i + 1));
    idle(5);

    // Continuous offer of 30 words fills the FIFO during a frame and exerts backpressure.
    ready_low_cnt = 0;
    for (int i = 1; i <= 30; i++) push_word(16'h0400 + 16'(i));
    drain();
    check("in_ready_low_seen", {31'd0, ready_low_cnt > 0}, 1);
    idle(5);

    // Reset during the 4th payload word, then a clean frame.
    for (int i = 1; i <= 10; i++) push_word(16'h0500 + 16'(i));
    for (int i = 0; i < 20 && !frame_start; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_frame_start_seen", {31'd0, frame_start}, 1);
    repeat (6) @(posedge clk);
    #1;
    check("mid_fourth_payload", {16'd0, outp}, 32'h0504);
    do_reset();
    idle(10);
    for (int i = 1; i <= 10; i++) push_word(16'h0600 + 16'(i));
    drain();
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/header_framer.md
# header_framer

Transmit-side framer for the 16-bit sample link. Buffers incoming payload words in a small FIFO. Once a full frame is buffered, it emits a header of HDR_LEN copies of HDR_WORD followed immediately by PAYLOAD_LEN contiguous payload words. Between frames it drives IDLE_WORD. Its output feeds the link whose far end runs the header detector: three 0xFFFF words open a 10-word data window.

## Interface
- WIDTH, 16: link word width
- HDR_WORD, 16'hFFFF: header marker word
- HDR_LEN, 3: header words per frame (≥1)
- PAYLOAD_LEN, 10: payload words per frame (1..FIFO_DEPTH)
- FIFO_DEPTH, 16: payload buffer depth (power of two)
- IDLE_WORD, 16'h0000: word driven while idle (must differ from HDR_WORD)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  payload word
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  buffer can accept; transfer when in_valid & in_ready
- outp  out  WIDTH  registered link word
- frame_start  out  1  registered; high with the first header word
- busy  out  1  registered; high while header or payload is on outp

## Operation
- Reset: outp=IDLE_WORD, frame_start=0, busy=0, FIFO empty, state IDLE. Reset mid-frame truncates the frame. The far end sees IDLE_WORD for the rest of its window; this is accepted.
- in_ready = !full (combinational from FIFO level). A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- FSM states: IDLE, HDR, PAY; header counter 0..HDR_LEN-1; payload counter 0..PAYLOAD_LEN-1.
- IDLE: outp<=IDLE_WORD, busy<=0. If level ≥ PAYLOAD_LEN: go to HDR, outp<=HDR_WORD, frame_start<=1, busy<=1, hdr_cnt<=1.
- HDR: outp<=HDR_WORD until HDR_LEN header words have been driven. On the cycle after the last header word, move to PAY and drive the first popped word.
- PAY: each cycle pop one word and drive outp<=fifo head. After the PAYLOAD_LEN-th word:
  - if level (after this cycle's push/pop) ≥ PAYLOAD_LEN, go directly to HDR (back-to-back frame, no idle gap);
  - otherwise go to IDLE.
- Level bookkeeping: a simultaneous push and pop leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH. The level counter is log2(FIFO_DEPTH)+1 bits.
- A payload word equal to HDR_WORD is transmitted unchanged. The far end ignores it inside the window.
- frame_start is high for exactly one cycle per frame.

## Timing
- The decision to start is made on the edge where level ≥ PAYLOAD_LEN is seen in IDLE. The first header word appears on outp in the next cycle.
- Frame occupies exactly HDR_LEN+PAYLOAD_LEN consecutive cycles on outp.
- Minimum input-to-output latency: the PAYLOAD_LEN-th word is accepted at edge t. Then:
  - IDLE decision at edge t+1;
  - header on cycles t+1..t+HDR_LEN;
  - first payload word at t+HDR_LEN+1.
- Back-to-back frames: the next frame's first header word follows the previous last payload word with zero gap. This matches the far end, which returns to header search the cycle after its 10th window word.
- FIFO read is show-ahead (head word combinationally available). outp is always a flop output.

## Structure
- Shared package `link_pkg`: WIDTH, HDR_WORD, HDR_LEN, PAYLOAD_LEN, IDLE_WORD constants and the FSM state encoding. These constants are shared with the detector side.
- One sub-module, `sync_fifo` (show-ahead, parameters WIDTH/DEPTH, ports push/pop/full/empty/level/rd_data, async active-high reset).
- The framer FSM, counters and output registers live in `header_framer`.

## Test plan
- Reset with FIFO holding 5 words → outp=0x0000, busy=0, frame_start=0, in_ready=1, level=0 after release.
- Push 10 words 0x0001..0x000A in consecutive cycles → outp shows FFFF,FFFF,FFFF,0001..000A contiguously, then 0x0000; frame_start high only with the first FFFF.
- Push 9 words only → outp stays 0x0000 indefinitely; 10th word triggers a frame one cycle after its acceptance.
- Stream 20 words continuously → two frames back-to-back (26 busy cycles, no idle word between frame 1's 0x000A and frame 2's first FFFF). A loopback header detector outputs all 20 words.
- Fill FIFO to 16 with in_valid held high during a frame → in_ready=0 while level=16, no word lost or duplicated, payload order preserved.
- Assert rst during the 4th payload word → outp=0x0000 immediately (async), FIFO empty. The next 10 pushes produce a clean new frame.
